tgl_hs_responder: RTL and testbench
===================================

TGL_HS_RESPONDER -- requirements
Module: tgl_hs_responder

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, meaning payload width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 4, meaning receive FIFO entries; legal values are powers of two, 2 or greater.
REQ-003 The module SHALL have parameter SYNC_STAGES, default 2, meaning the number of req_tgl synchronizer flops; legal values are 2 or greater.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The module SHALL have port req_tgl, input, 1 bit: two-phase request from the initiator; each level change marks one transfer.
REQ-007 The module SHALL have port req_data, input, DATA_W bits: payload, held stable by the initiator from its req_tgl toggle until the matching ack_tgl toggle.
REQ-008 The module SHALL have port ack_tgl, output, 1 bit: two-phase acknowledge; one level change per accepted transfer.
REQ-009 The module SHALL have port out_valid, output, 1 bit: the FIFO head is valid.
REQ-010 The module SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the head.
REQ-011 The module SHALL have port out_data, output, DATA_W bits: the FIFO head payload.
REQ-012 The module SHALL have port busy, output, 1 bit: a request is pending and stalled because the FIFO is full.
REQ-013 The module SHALL have port proto_err, output, 1 bit: sticky protocol-violation flag.
REQ-014 The module SHALL have port xfer_cnt, output, 16 bits: count of accepted transfers.

Function
REQ-015 req_tgl SHALL pass through SYNC_STAGES flops; req_s denotes the last stage and req_s_d denotes req_s delayed one cycle.
REQ-016 A request SHALL be pending while req_s != ack_tgl.
REQ-017 The FSM SHALL have two states, IDLE and STALL.
REQ-018 In IDLE, a pending request with FIFO count < DEPTH SHALL, on that clock edge, push req_data, toggle ack_tgl, and increment xfer_cnt; the state SHALL remain IDLE.
REQ-019 In IDLE, a pending request with FIFO count == DEPTH SHALL move the FSM to STALL without pushing or toggling.
REQ-020 In STALL, busy SHALL be 1; on the first edge at which count < DEPTH, the push and ack_tgl toggle SHALL occur and the FSM SHALL return to IDLE.
REQ-021 The push SHALL occur at the (SYNC_STAGES+1)th rising edge after a req_tgl change that meets setup, provided the FIFO is not full; out_valid SHALL rise one cycle later.
REQ-022 Pushes SHALL be blocked whenever count == DEPTH, even when a pop occurs in the same cycle; there is no full bypass.
REQ-023 A pop SHALL occur when out_valid and out_ready are both 1.
REQ-024 A simultaneous push and pop with count in 1..DEPTH-1 SHALL leave count unchanged; a push into an empty FIFO SHALL not be visible on out_data until the next cycle.
REQ-025 out_valid SHALL equal (count != 0), and out_data SHALL equal mem[rd_ptr].
REQ-026 out_data SHALL be don't-care while out_valid is 0.
REQ-027 rd_ptr and wr_ptr SHALL wrap modulo DEPTH.
REQ-028 count SHALL be $clog2(DEPTH)+1 bits wide.
REQ-029 xfer_cnt SHALL wrap from 16'hFFFF to 0.
REQ-030 A req_s != req_s_d change that occurs while a request is already pending SHALL set proto_err; proto_err SHALL remain 1 until rst.

Reset
REQ-031 rst SHALL asynchronously clear all synchronizer flops, req_s_d, ack_tgl, FIFO pointers and count, xfer_cnt, proto_err, and the FSM (to IDLE).
REQ-032 During and immediately after reset, ack_tgl, out_valid, busy, and proto_err SHALL be 0, and xfer_cnt SHALL be 0.
REQ-033 Reset asserted mid-transfer SHALL discard FIFO contents and any pending request; the initiator is responsible for realigning req_tgl to 0.

Structure
REQ-034 Package tgl_hs_pkg SHALL hold the FSM state typedef (IDLE, STALL) and the default constants DATA_W_DEF=8, DEPTH_DEF=4, and SYNC_STAGES_DEF=2.
REQ-035 The FIFO SHALL be a sub-module named tgl_fifo with push, pop, full, empty, and count ports; the synchronizer and FSM SHALL be written inline.

Verification
REQ-036 Scenario "single transfer": after reset, toggle req_tgl 0->1 with req_data=8'hA5 -> ack_tgl goes 0->1 at the 3rd edge, out_valid=1 and out_data=8'hA5 at the next edge, and xfer_cnt=1.
REQ-037 Scenario "fill and stall": with out_ready=0, send 5 transfers with data 1..5, each waiting for its ack -> 4 acks, then busy=1 on the 5th; raising out_ready for one cycle pops 1, the 5th is acked, and busy returns to 0.
REQ-038 Scenario "stream": with out_ready=1, send 20 transfers of random data -> the output order equals the input order, with no loss or duplication across pointer wraps.
REQ-039 Scenario "protocol error": toggle req_tgl twice, 1 cycle apart, without waiting for ack -> proto_err=1, and it stays 1 until rst.
REQ-040 Scenario "reset mid-operation": assert rst with 3 entries queued and a request pending -> out_valid=0, ack_tgl=0, xfer_cnt=0, and a new transfer after rst completes normally.
REQ-041 Scenario "counter wrap": preload by running 65536 transfers -> xfer_cnt reads 0, and the next transfer makes it 1.

Source files
------------

// File: rtl/tgl_hs_pkg.sv
// Shared types and default constants for the two-phase handshake responder.
package tgl_hs_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } hs_state_t;

    localparam int DATA_W_DEF      = 8;
    localparam int DEPTH_DEF       = 4;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int XFER_CNT_W      = 16;

endpackage

// File: rtl/tgl_fifo.sv
// Power-of-two circular FIFO; storage is left unreset, only pointers and count clear.
module tgl_fifo
    import tgl_hs_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop,
    output logic [DATA_W-1:0]      pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    // A full FIFO refuses pushes even if a pop frees a slot on the same edge.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tgl_hs_responder.sv
// Two-phase (toggle) handshake responder: synchronizes req_tgl, queues payloads
// into a small FIFO and acknowledges each accepted transfer with an ack_tgl toggle.
module tgl_hs_responder
    import tgl_hs_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_tgl,
    input  logic [DATA_W-1:0]     req_data,
    output logic                  ack_tgl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  busy,
    output logic                  proto_err,
    output logic [XFER_CNT_W-1:0] xfer_cnt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic                   req_s_d;
    logic                   pending;
    logic                   pending_d;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    hs_state_t              state;
    hs_state_t              state_nxt;

    assign req_s   = sync_q[SYNC_STAGES-1];
    assign pending = req_s ^ ack_tgl;
    // The same accept rule serves both states; STALL only re-tries it each edge.
    assign push    = pending && !fifo_full;
    assign pop     = out_ready && !fifo_empty;

    assign out_valid = (fifo_count != '0);
    assign busy      = (state == STALL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            req_s_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], req_tgl};
            req_s_d <= req_s;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pending && fifo_full) state_nxt = STALL;
            STALL:   if (!fifo_full)           state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A req edge arriving while the previous request was still un-acked on the
    // prior edge can only come from an initiator that did not wait for ack_tgl.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ack_tgl   <= 1'b0;
            xfer_cnt  <= '0;
            pending_d <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            ack_tgl   <= ack_tgl ^ push;
            xfer_cnt  <= xfer_cnt + {{(XFER_CNT_W-1){1'b0}}, push};
            pending_d <= pending;
            proto_err <= proto_err | ((req_s ^ req_s_d) & pending_d);
        end
    end

    tgl_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (req_data),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_tgl_hs_responder.sv
// Self-checking bench for tgl_hs_responder: queue-based reference model plus directed scenarios.
module tb_tgl_hs_responder;

    localparam int DATA_W      = 8;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int WRAP_N      = 65536;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_tgl = 1'b0;
    logic [DATA_W-1:0] req_data = '0;
    logic              out_ready = 1'b0;
    logic              ack_tgl;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              proto_err;
    logic [15:0]       xfer_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tgl_hs_responder #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_tgl   (req_tgl),
        .req_data  (req_data),
        .ack_tgl   (ack_tgl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .proto_err (proto_err),
        .xfer_cnt  (xfer_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: req history line, ack level, payload queue, counters.
    bit              m_hist[$];
    bit              m_ack;
    bit              m_busy;
    bit              m_err;
    bit              m_pend_prev;
    bit              m_req_s_d;
    logic [DATA_W-1:0] m_q[$];
    int              m_total;

    always @(posedge clk or posedge rst) begin : model
        bit req_s;
        bit pending;
        bit full;
        bit do_pop;
        bit do_push;
        if (rst) begin
            m_hist.delete();
            for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(1'b0);
            m_ack = 0; m_busy = 0; m_err = 0; m_pend_prev = 0; m_req_s_d = 0;
            m_q.delete();
            m_total = 0;
        end else begin
            req_s   = m_hist[0];
            pending = (req_s != m_ack);
            full    = (m_q.size() == DEPTH);
            do_pop  = (m_q.size() != 0) && out_ready;
            do_push = pending && !full;
            if ((req_s != m_req_s_d) && m_pend_prev) m_err = 1;
            m_pend_prev = pending;
            m_busy      = pending && full;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back(req_data);
                m_ack = !m_ack;
                m_total++;
            end
            m_req_s_d = req_s;
            m_hist.push_back(req_tgl);
            void'(m_hist.pop_front());
        end
    end

    always @(posedge clk) begin : compare
        #1;
        check("ack_tgl", ack_tgl, m_ack);
        check("out_valid", out_valid, m_q.size() != 0);
        if (m_q.size() != 0) check("out_data", out_data, m_q[0]);
        check("busy", busy, m_busy);
        check("proto_err", proto_err, m_err);
        check("xfer_cnt", xfer_cnt, m_total[15:0]);
    end

    logic [DATA_W-1:0] rx_q[$];
    logic [DATA_W-1:0] tx_q[$];

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) rx_q.push_back(out_data);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic toggle(input logic [DATA_W-1:0] d);
        @(negedge clk);
        req_data = d;
        req_tgl  = ~req_tgl;
    endtask

    task automatic wait_ack(input string name, input int budget);
        int k = 0;
        while (ack_tgl !== req_tgl && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, ack_tgl, req_tgl);
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        toggle(d);
        wait_ack("ack_wait", 20);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_ack;
        int   guard;

        // Reset state
        tick(3);
        check("rst_ack", ack_tgl, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", proto_err, 0);
        check("rst_xfer", xfer_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        tick(2);

        // Single transfer: ack on the 3rd edge, head visible by the 4th
        @(negedge clk);
        req_data = 8'hA5;
        req_tgl  = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("single_ack_early", ack_tgl, 0);
        @(posedge clk);
        #1 check("single_ack", ack_tgl, 1);
        check("single_xfer", xfer_cnt, 1);
        @(posedge clk);
        #1 check("single_valid", out_valid, 1);
        check("single_data", out_data, 8'hA5);
        @(negedge clk) out_ready = 1'b1;
        @(negedge clk) out_ready = 1'b0;
        check("single_drained", out_valid, 0);

        // Fill and stall
        for (int i = 1; i <= 4; i++) send(8'(i));
        toggle(8'd5);
        tick(6);
        exp_ack = ~req_tgl;
        check("stall_busy", busy, 1);
        check("stall_no_ack", ack_tgl, exp_ack);
        check("stall_head", out_data, 8'd1);
        @(negedge clk) out_ready = 1'b1;
        @(negedge clk) out_ready = 1'b0;
        wait_ack("stall_release_ack", 20);
        check("stall_busy_clear", busy, 0);
        check("stall_head_after", out_data, 8'd2);
        check("stall_xfer", xfer_cnt, 6);
        out_ready = 1'b1;
        tick(8);
        check("fill_drained", out_valid, 0);

        // Stream with continuous readiness
        rx_q.delete();
        tx_q.delete();
        for (int i = 0; i < 20; i++) begin
            logic [DATA_W-1:0] d;
            d = DATA_W'($urandom);
            tx_q.push_back(d);
            send(d);
        end
        tick(6);
        check("stream_count", rx_q.size(), 20);
        for (int i = 0; i < 20; i++) begin
            if (i < rx_q.size()) check("stream_order", rx_q[i], tx_q[i]);
        end

        // Protocol error: two toggles one cycle apart
        toggle(8'h11);
        toggle(8'h22);
        tick(8);
        check("proto_set", proto_err, 1);
        tick(20);
        check("proto_sticky", proto_err, 1);

        // Reset mid-operation
        out_ready = 1'b0;
        tick(4);
        send(8'h31);
        send(8'h32);
        send(8'h33);
        toggle(8'h34);
        tick(1);
        @(negedge clk);
        rst     = 1'b1;
        req_tgl = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_ack", ack_tgl, 0);
        check("midrst_xfer", xfer_cnt, 0);
        check("midrst_err", proto_err, 0);
        tick(3);
        rst = 1'b0;
        tick(2);
        send(8'h3C);
        check("postrst_xfer", xfer_cnt, 1);
        tick(1);
        check("postrst_valid", out_valid, 1);
        check("postrst_data", out_data, 8'h3C);

        // Counter wrap: fast toggling preload, then clean handshakes to the boundary
        out_ready = 1'b1;
        guard = 0;
        while (m_total < WRAP_N - 8 && guard < 70000) begin
            @(negedge clk);
            req_data = DATA_W'($urandom);
            req_tgl  = ~req_tgl;
            guard++;
        end
        check("wrap_preload_budget", guard < 70000, 1);
        tick(8);
        check("wrap_quiet", ack_tgl, req_tgl);
        guard = 0;
        while (m_total < WRAP_N && guard < 20) begin
            send(DATA_W'($urandom));
            guard++;
        end
        check("wrap_zero", xfer_cnt, 16'h0000);
        send(8'h5A);
        check("wrap_one", xfer_cnt, 16'h0001);
        check("wrap_err_sticky", proto_err, 1);
        tick(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
